memory_stage_queue: RTL and testbench
=====================================

// Module: memory_stage_queue
// PURPOSE
//   Multi-lane in-order queue carrying memory-stage payloads (packed instr/rd/aluout/writereg/hi/lo/pcplus4
//   records) from execute to memory/writeback. Accepts up to LANES entries per cycle and delivers up to
//   LANES per cycle, oldest first. Supports flush on exception/redirect. Replaces the single-entry
//   execute->memory pipeline register; sized for dual-issue.
// PARAMETERS
//   WIDTH  default 256  payload bits per entry (set to $bits(memory_pkg::memory_data_t) at instantiation)
//   DEPTH  default 8    entries; power of two, DEPTH >= 2*LANES
//   LANES  default 2    enqueue/dequeue lanes per cycle, 1..4
// PORTS
//   clk        in   1                   clock, all state on posedge
//   reset      in   1                   synchronous, active-high
//   flush      in   1                   discard all contents and this cycle's enqueue
//   in_valid   in   LANES               per-lane enqueue request, any subset
//   in_data    in   LANES*WIDTH         lane i payload at [i*WIDTH +: WIDTH]
//   in_ready   out  1                   queue can take LANES entries this cycle
//   out_valid  out  LANES               lane i holds the i-th oldest entry
//   out_data   out  LANES*WIDTH         lane i payload, oldest in lane 0
//   out_ready  in   LANES               per-lane consumer accept
//   count      out  $clog2(DEPTH+1)     current occupancy
// BEHAVIOUR
//   Reset: count=0, rd_ptr=wr_ptr=0, out_valid=0, in_ready=1; out_data don't-care while invalid.
//   State: DEPTH x WIDTH array, rd_ptr/wr_ptr of $clog2(DEPTH) bits wrapping modulo DEPTH, count register.
//   in_ready = (DEPTH - count) >= LANES, from registered count only (no same-cycle dequeue credit).
//   Enqueue: if in_ready && !flush, the lanes with in_valid set are compacted in ascending lane order
//     and written at wr_ptr, wr_ptr+1, ... (mod DEPTH); enq_n = popcount(in_valid). Lane 0 invalid with
//     lane 1 valid: lane 1 data goes to wr_ptr. If !in_ready, in_valid is ignored (producer holds).
//   Dequeue: out_valid[i] = (count > i); out_data lane i = mem[rd_ptr+i mod DEPTH], combinational from
//     storage (no bypass: an entry written this cycle is visible next cycle, 1-cycle min latency).
//     deq_n = length of the leading run of lanes with out_valid[i] && out_ready[i]; a lane accepted after
//     a non-accepting lane is NOT consumed (in-order retire). rd_ptr += deq_n.
//   Update: count' = count + enq_n - deq_n; simultaneous enqueue and dequeue both take effect.
//   Full: count > DEPTH-LANES -> in_ready=0 even if a dequeue happens this cycle.
//   Empty: count=0 -> out_valid all 0; out_ready ignored.
//   Flush (priority over enq/deq): next cycle count=0, rd_ptr=wr_ptr=0, out_valid=0; storage untouched.
//   Reset asserted mid-operation behaves exactly as flush plus reset values; reset overrides flush.
//   Throughput: with DEPTH >= 2*LANES and consumer always ready, sustains LANES entries/cycle.
//   Assertions (sim only): count <= DEPTH; out_ready[i] with !out_valid[i] has no effect.
// TESTING
//   1 Reset then in_valid=2'b11, data A,B; out_ready=0 -> next cycle count=2, out_data lane0=A, lane1=B.
//   2 Compaction: in_valid=2'b10 data C in lane1 -> C appears in out lane0 next cycle, count=1.
//   3 Fill DEPTH=8 with 4 double enqueues, no dequeue -> count=8, in_ready=0; extra in_valid ignored.
//   4 out_ready=2'b10 with 2 entries -> nothing dequeued; out_ready=2'b01 -> only lane0 consumed, count-1.
//   5 Wrap: 20 cycles of 2-in/2-out, data = incrementing seq -> output strictly 0,1,2,..., count stays 2.
//   6 flush with in_valid=2'b11, count=5 -> next cycle count=0, out_valid=0, in_ready=1; pointers 0.

Source files
------------

// File: rtl/memory_stage_queue.sv
// Multi-lane in-order queue between execute and memory/writeback.
// Takes up to LANES payloads per cycle (compacted) and presents the LANES oldest, retiring in order.
module memory_stage_queue #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LANES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [LANES-1:0]             in_valid,
    input  logic [LANES*WIDTH-1:0]       in_data,
    output logic                         in_ready,
    output logic [LANES-1:0]             out_valid,
    output logic [LANES*WIDTH-1:0]       out_data,
    input  logic [LANES-1:0]             out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] MaxFill = CW'(DEPTH - LANES);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic             do_enq;
    logic [CW-1:0]    enq_n;
    logic [CW-1:0]    enq_cnt;
    logic [CW-1:0]    deq_n;
    logic [PW-1:0]    enq_off [LANES];
    logic             run;

    // Readiness uses registered occupancy only; a same-cycle dequeue earns no credit.
    assign in_ready = (count_q <= MaxFill);
    assign do_enq   = in_ready && !flush;
    assign count    = count_q;

    // Compaction: each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        enq_n = '0;
        for (int i = 0; i < LANES; i++) begin
            enq_off[i] = PW'(enq_n);
            if (in_valid[i]) begin
                enq_n = enq_n + CW'(1);
            end
        end
    end

    assign enq_cnt = do_enq ? enq_n : '0;

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            out_valid[i]                 = (count_q > CW'(i));
            out_data[i*WIDTH +: WIDTH]   = mem[rd_ptr_q + PW'(i)];
        end
    end

    // Only the leading run of accepted lanes retires; anything past a stalled lane stays.
    always_comb begin
        deq_n = '0;
        run   = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (run && out_valid[i] && out_ready[i]) begin
                deq_n = deq_n + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(deq_n);
        wr_ptr_d = wr_ptr_q + PW'(enq_cnt);
        count_d  = count_q + enq_cnt - deq_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; flush and reset only move the pointers.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_valid[i]) begin
                    mem[wr_ptr_q + enq_off[i]] <= in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count_q <= CW'(DEPTH));
            assert (deq_n <= count_q);
        end
    end

endmodule

// File: tb/tb_memory_stage_queue.sv
// Bench for memory_stage_queue: directed scenarios plus randomized traffic against a queue model.
module tb_memory_stage_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LANES = 2;
    localparam int unsigned CW    = $clog2(DEPTH+1);

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       flush;
    logic [LANES-1:0]           in_valid;
    logic [LANES*WIDTH-1:0]     in_data;
    logic                       in_ready;
    logic [LANES-1:0]           out_valid;
    logic [LANES*WIDTH-1:0]     out_data;
    logic [LANES-1:0]           out_ready;
    logic [CW-1:0]              count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    logic [WIDTH-1:0] q [$];

    memory_stage_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .LANES (LANES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue-level reference: retire the accepted prefix, then append valid lanes in lane order.
    task automatic model_step();
        int n;
        bit rdy;
        if (reset || flush) begin
            q.delete();
            return;
        end
        rdy = (DEPTH - q.size()) >= LANES;
        n = 0;
        for (int i = 0; i < LANES; i++) begin
            if (n == i && i < q.size() && out_ready[i]) n++;
        end
        repeat (n) void'(q.pop_front());
        if (rdy) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_valid[i]) q.push_back(in_data[i*WIDTH +: WIDTH]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        started = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        int sz;
        if (started) begin
            sz = q.size();
            chk("count", 64'(count), 64'(sz));
            chk("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= LANES));
            for (int i = 0; i < LANES; i++) begin
                chk("out_valid", 64'(out_valid[i]), 64'(i < sz));
                if (i < sz) chk("out_data", 64'(out_data[i*WIDTH +: WIDTH]), 64'(q[i]));
            end
        end
    end

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
    endtask

    task automatic do_flush();
        idle_inputs();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic enq2(input logic [1:0] v, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1);
        in_valid = v;
        in_data  = {d1, d0};
        tick();
        in_valid = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // Two-lane enqueue, visible next cycle in order
        enq2(2'b11, 32'hAAAA_0001, 32'hBBBB_0002);
        chk("t1_count", 64'(count), 64'd2);
        chk("t1_lane0", 64'(out_data[0 +: WIDTH]), 64'hAAAA_0001);
        chk("t1_lane1", 64'(out_data[WIDTH +: WIDTH]), 64'hBBBB_0002);

        // Compaction of lane 1 into slot 0
        do_flush();
        enq2(2'b10, 32'h0, 32'hCCCC_0003);
        chk("t2_count", 64'(count), 64'd1);
        chk("t2_lane0", 64'(out_data[0 +: WIDTH]), 64'hCCCC_0003);
        chk("t2_valid", 64'(out_valid), 64'b01);

        // Fill to DEPTH, further enqueue ignored
        do_flush();
        for (int k = 0; k < 4; k++) enq2(2'b11, 32'(100 + 2*k), 32'(101 + 2*k));
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        enq2(2'b11, 32'hDEAD_0000, 32'hDEAD_0001);
        chk("t3_hold", 64'(count), 64'd8);
        chk("t3_head", 64'(out_data[0 +: WIDTH]), 64'd100);

        // In-order retire: a lane past a stalled lane is not consumed
        do_flush();
        enq2(2'b11, 32'hD0, 32'hE0);
        out_ready = 2'b10;
        tick();
        chk("t4_stall", 64'(count), 64'd2);
        out_ready = 2'b01;
        tick();
        out_ready = 2'b00;
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_head", 64'(out_data[0 +: WIDTH]), 64'hE0);

        // Steady 2-in/2-out across pointer wrap
        do_flush();
        for (int c = 0; c < 20; c++) begin
            in_valid  = 2'b11;
            in_data   = {32'(2*c + 1), 32'(2*c)};
            out_ready = 2'b11;
            tick();
            chk("t5_count", 64'(count), 64'd2);
            chk("t5_lane0", 64'(out_data[0 +: WIDTH]), 64'(2*c));
            chk("t5_lane1", 64'(out_data[WIDTH +: WIDTH]), 64'(2*c + 1));
        end
        idle_inputs();

        // Flush overrides a concurrent enqueue; pointers restart at 0
        do_flush();
        enq2(2'b11, 32'h51, 32'h52);
        enq2(2'b11, 32'h53, 32'h54);
        enq2(2'b01, 32'h55, 32'h0);
        chk("t6_pre", 64'(count), 64'd5);
        flush    = 1'b1;
        in_valid = 2'b11;
        in_data  = {32'h66, 32'h65};
        tick();
        idle_inputs();
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        enq2(2'b01, 32'hF00D, 32'h0);
        chk("t6_after", 64'(out_data[0 +: WIDTH]), 64'hF00D);

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 600; c++) begin
            in_valid  = LANES'($urandom_range(0, (1 << LANES) - 1));
            in_data   = {$urandom(), $urandom()};
            out_ready = LANES'($urandom_range(0, (1 << LANES) - 1));
            flush     = ($urandom_range(0, 31) == 0);
            reset     = ($urandom_range(0, 63) == 0);
            tick();
        end
        idle_inputs();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
